mux_rr_reg: RTL and testbench

//  Parametrised NCH-way, WIDTH-bit channel multiplexer with one registered output stage and

---
 rtl/mux_rr_reg.sv | 117 +++++++++++
 tb/tb_mux_rr_reg.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_reg.sv
// mux_rr_reg: NCH-way valid/ready channel mux, one registered output stage, fixed or
// round-robin selection. Define MUX_PARITY_EN to add the OutPar even-parity output.
module mux_rr_reg #(
    parameter int WIDTH = 2,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [NCH*WIDTH-1:0] In,
    input  logic [NCH-1:0]       InVld,
    output logic [NCH-1:0]       InRdy,
    input  logic                 Mode,
    input  logic [SELW-1:0]      Sel,
    output logic [WIDTH-1:0]     Out,
    output logic                 OutVld,
    input  logic                 OutRdy,
    output logic [SELW-1:0]      OutCh
`ifdef MUX_PARITY_EN
    ,
    output logic                 OutPar
`endif
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] out_q, out_d;
    logic [SELW-1:0]  ch_q, ptr_q, ptr_d;
    logic [SELW-1:0]  gnt_idx, idx;
    logic [NCH-1:0]   gnt;
    logic             gnt_any, ld;

    // A new word may enter when the stage is empty or is being drained this cycle.
    assign ld = (state_q == EMPTY) | OutRdy;

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        if (ld) begin
            if (!Mode) begin
                for (int k = 0; k < NCH; k++) begin
                    if (Sel == SELW'(k) && InVld[k]) begin
                        gnt_any = 1'b1;
                        gnt_idx = SELW'(k);
                    end
                end
            end else begin
                // Rotation wraps at NCH, not at 2**SELW.
                for (int i = 0; i < NCH; i++) begin
                    idx = SELW'((int'(ptr_q) + i) % NCH);
                    if (!gnt_any && InVld[idx]) begin
                        gnt_any = 1'b1;
                        gnt_idx = idx;
                    end
                end
            end
        end
    end

    always_comb begin
        gnt   = '0;
        out_d = '0;
        for (int k = 0; k < NCH; k++) begin
            if (gnt_idx == SELW'(k)) begin
                gnt[k] = gnt_any;
                out_d  = In[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any && Mode)
            ptr_d = (gnt_idx == SELW'(NCH-1)) ? '0 : gnt_idx + SELW'(1);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= EMPTY;
            out_q   <= '0;
            ch_q    <= '0;
            ptr_q   <= '0;
        end else begin
            ptr_q <= ptr_d;
            case (state_q)
                EMPTY:   if (gnt_any) state_q <= FULL;
                FULL:    if (OutRdy && !gnt_any) state_q <= EMPTY;
                default: state_q <= EMPTY;
            endcase
            if (gnt_any) begin
                out_q <= out_d;
                ch_q  <= gnt_idx;
            end
        end
    end

`ifdef MUX_PARITY_EN
    logic par_q;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            par_q <= 1'b0;
        else if (gnt_any)
            par_q <= ^out_d;
    end

    assign OutPar = par_q;
`endif

    assign InRdy  = gnt;
    assign Out    = out_q;
    assign OutVld = (state_q == FULL);
    assign OutCh  = ch_q;

endmodule

// File: tb/tb_mux_rr_reg.sv
// Bench for mux_rr_reg: directed vectors, a transaction-level reference model checked every
// cycle, plus literal expectations. Second instance covers NCH=3 with an out-of-range Sel.
module tb_mux_rr_reg;

    localparam int W = 2, N = 4, SW = 2, N3 = 3;

    logic          Clk = 0, Rst = 1;
    logic [N*W-1:0] In = '0;
    logic [N-1:0]  InVld = '0, InRdy;
    logic          Mode = 0, OutRdy = 0, OutVld;
    logic [SW-1:0] Sel = '0, OutCh;
    logic [W-1:0]  Out;

    logic [N3*W-1:0] In3 = '0;
    logic [N3-1:0]   InVld3 = '0, InRdy3;
    logic            Mode3 = 0, OutRdy3 = 0, OutVld3;
    logic [SW-1:0]   Sel3 = '0, OutCh3;
    logic [W-1:0]    Out3;

`ifdef MUX_PARITY_EN
    logic OutPar, OutPar3;
`endif

    mux_rr_reg #(.WIDTH(W), .NCH(N), .SELW(SW)) dut (
        .Clk(Clk), .Rst(Rst), .In(In), .InVld(InVld), .InRdy(InRdy), .Mode(Mode), .Sel(Sel),
        .Out(Out), .OutVld(OutVld), .OutRdy(OutRdy), .OutCh(OutCh)
`ifdef MUX_PARITY_EN
        , .OutPar(OutPar)
`endif
    );

    mux_rr_reg #(.WIDTH(W), .NCH(N3), .SELW(SW)) dut3 (
        .Clk(Clk), .Rst(Rst), .In(In3), .InVld(InVld3), .InRdy(InRdy3), .Mode(Mode3), .Sel(Sel3),
        .Out(Out3), .OutVld(OutVld3), .OutRdy(OutRdy3), .OutCh(OutCh3)
`ifdef MUX_PARITY_EN
        , .OutPar(OutPar3)
`endif
    );

    always #5 Clk = ~Clk;

    int n_chk = 0, n_pass = 0;
    bit run_cmp = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Reference model: one output slot plus a rotating start index.
    int m_vld, m_out, m_ch, m_par, m_ptr;

    function automatic int exp_grant();
        if (m_vld != 0 && !OutRdy) return -1;
        if (!Mode) return (int'(Sel) < N && InVld[Sel]) ? int'(Sel) : -1;
        for (int i = 0; i < N; i++)
            if (InVld[(m_ptr + i) % N]) return (m_ptr + i) % N;
        return -1;
    endfunction

    always @(posedge Clk or posedge Rst) begin
        int g;
        if (Rst) begin
            m_vld = 0; m_out = 0; m_ch = 0; m_par = 0; m_ptr = 0;
        end else begin
            g = exp_grant();
            if (g >= 0) begin
                m_vld = 1;
                m_out = int'(In[g*W +: W]);
                m_ch  = g;
                m_par = int'(^In[g*W +: W]);
                if (Mode) m_ptr = (g + 1) % N;
            end else if (OutRdy) begin
                m_vld = 0;
            end
        end
    end

    always @(negedge Clk) begin
        int g;
        if (run_cmp) begin
            g = exp_grant();
            check("cmp_inrdy", int'(InRdy), (g < 0) ? 0 : (1 << g));
            check("cmp_outvld", int'(OutVld), m_vld);
            if (m_vld != 0) begin
                check("cmp_out", int'(Out), m_out);
                check("cmp_outch", int'(OutCh), m_ch);
`ifdef MUX_PARITY_EN
                check("cmp_outpar", int'(OutPar), m_par);
`endif
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        int seq[5] = '{0, 1, 3, 0, 1};
        int par_exp[4] = '{0, 1, 1, 0};

        // Reset state
        #1;
        check("rst_out", int'(Out), 0);
        check("rst_outvld", int'(OutVld), 0);
        check("rst_outch", int'(OutCh), 0);
        tick();
        Rst = 0;
        run_cmp = 1;

        // 1: fixed mode sweep
        In = 8'b11_10_01_00; InVld = 4'b1111; OutRdy = 1; Mode = 0;
        for (int s = 0; s < 4; s++) begin
            Sel = SW'(s);
            tick();
            check("fix_out", int'(Out), s);
            check("fix_ch", int'(OutCh), s);
            check("fix_vld", int'(OutVld), 1);
        end

        // 2: backpressure on channel 2
        Sel = 2;
        tick();
        check("bp_load", int'(Out), 2);
        OutRdy = 0; In = 8'b00_01_10_11;
        #1 check("bp_inrdy0", int'(InRdy), 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("bp_hold", int'(Out), 2);
            check("bp_stall_rdy", int'(InRdy), 0);
        end
        OutRdy = 1;
        #1 check("bp_release_rdy", int'(InRdy), 4'b0100);
        tick();
        check("bp_next", int'(Out), 1);
        check("bp_next_vld", int'(OutVld), 1);

        // 3: round-robin with a gap at channel 2
        Mode = 1; In = 8'b11_10_01_00; InVld = 4'b1011;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rr_ch", int'(OutCh), seq[i]);
            check("rr_out", int'(Out), seq[i]);
        end
        InVld = 4'b0000;
        tick();
        check("rr_drop", int'(OutVld), 0);
        tick();
        InVld = 4'b1111;
        tick();
        check("rr_ptr_kept", int'(OutCh), 2);

        // 4: async reset while full and stalled
        InVld = 4'b0010;
        tick();
        check("pre_rst_ch", int'(OutCh), 1);
        OutRdy = 0; InVld = 4'b0000;
        tick();
        check("pre_rst_hold", int'(OutVld), 1);
        #2 Rst = 1;
        #1;
        check("arst_out", int'(Out), 0);
        check("arst_vld", int'(OutVld), 0);
        check("arst_ch", int'(OutCh), 0);
        tick();
        Rst = 0;
        InVld = 4'b1111; OutRdy = 1; Mode = 1; In = 8'b11_10_01_00;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("post_rst_rr", int'(OutCh), k);
`ifdef MUX_PARITY_EN
            check("par_lit", int'(OutPar), par_exp[k]);
`else
            check("post_rst_out", int'(Out), k + 0 * par_exp[k]);
`endif
        end

        // 5: NCH=3 with out-of-range Sel
        In3 = 6'b10_01_00; InVld3 = 3'b111; Mode3 = 0; Sel3 = 3; OutRdy3 = 1;
        #1 check("n3_rdy_none", int'(InRdy3), 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("n3_vld_low", int'(OutVld3), 0);
            check("n3_rdy_low", int'(InRdy3), 0);
        end
        Sel3 = 2;
        #1 check("n3_rdy_sel2", int'(InRdy3), 3'b100);
        tick();
        check("n3_out", int'(Out3), 2);
        check("n3_ch", int'(OutCh3), 2);

        run_cmp = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
